// File: rtl/permuter_swap_stage_pkg.sv
// permuter_swap_stage_pkg: shared flit geometry defaults and lane encoding for the swap stage.
package permuter_swap_stage_pkg;
  localparam int WIDTH_INTERNAL_PV = 64;
  localparam int PV_WIDTH = 4;
  localparam int AGE_WIDTH = 8;
  localparam int ID_WIDTH = 8;
  localparam int GOLDEN_EPOCH_DEF = 64;
  typedef enum logic {LANE0 = 1'b0, LANE1 = 1'b1} lane_e;
endpackage

// File: rtl/permuter_swap_stage_prio_cmp.sv
// flit_prio_cmp: decides whether lane 1 outranks lane 0 (valid, older, lower id, lane 0 on ties).
// PERMUTER_GOLDEN_PRIORITY_EN adds a golden-id override ahead of the age rules.
module flit_prio_cmp #(
  parameter int AGE_W = 8,
  parameter int ID_W = 8
) (
  input  logic             valid0,
  input  logic [AGE_W-1:0] age0,
  input  logic [ID_W-1:0]  id0,
  input  logic             valid1,
  input  logic [AGE_W-1:0] age1,
  input  logic [ID_W-1:0]  id1,
`ifdef PERMUTER_GOLDEN_PRIORITY_EN
  input  logic [ID_W-1:0]  goldenId,
`endif
  output logic             lane1Wins
);
  logic normal1;
  assign normal1 = valid1 & (~valid0 | (age1 > age0) | ((age1 == age0) & (id1 < id0)));
`ifdef PERMUTER_GOLDEN_PRIORITY_EN
  logic golden0, golden1;
  assign golden0 = valid0 & (id0 == goldenId);
  assign golden1 = valid1 & (id1 == goldenId);
  // exactly one golden flit overrides age; two golden flits fall back to normal order
  assign lane1Wins = (golden0 ^ golden1) ? golden1 : normal1;
`else
  assign lane1Wins = normal1;
`endif
endmodule

// File: rtl/permuter_swap_stage.sv
// permuter_swap_stage: registers a flit pair, ages valid flits, and computes the permuter swap.
// PERMUTER_GOLDEN_PRIORITY_EN enables the rotating golden-id priority override.
module permuter_swap_stage
  import permuter_swap_stage_pkg::*;
#(
  parameter int FLIT_W = WIDTH_INTERNAL_PV,
  parameter int PV_W = PV_WIDTH,
  parameter int PV_SEL = 0,
  parameter int AGE_W = AGE_WIDTH,
`ifdef PERMUTER_GOLDEN_PRIORITY_EN
  parameter int GOLDEN_EPOCH = GOLDEN_EPOCH_DEF,
`endif
  parameter int ID_W = ID_WIDTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic [FLIT_W-1:0] inFlit0,
  input  logic [FLIT_W-1:0] inFlit1,
  output logic [FLIT_W-1:0] outFlit0,
  output logic [FLIT_W-1:0] outFlit1,
  output logic              swap
);
  localparam int VALID_BIT = FLIT_W - 1;
  localparam int PV_LSB = FLIT_W - 1 - PV_W;
  localparam int AGE_MSB = PV_LSB - 1;
  localparam int AGE_LSB = AGE_MSB - AGE_W + 1;
  localparam int ID_MSB = AGE_LSB - 1;
  localparam int ID_LSB = ID_MSB - ID_W + 1;
  localparam int WANT_BIT = PV_LSB + PV_SEL;

  logic [AGE_W-1:0] age0, age1;
  logic [FLIT_W-1:0] next0, next1;
  logic lane1Wins, want, swapNext;
  lane_e winner;

  assign age0 = inFlit0[AGE_MSB:AGE_LSB];
  assign age1 = inFlit1[AGE_MSB:AGE_LSB];

`ifdef PERMUTER_GOLDEN_PRIORITY_EN
  localparam int CNT_W = (GOLDEN_EPOCH > 1) ? $clog2(GOLDEN_EPOCH) : 1;
  logic [CNT_W-1:0] goldenCnt;
  logic [ID_W-1:0] goldenId;
  logic epochWrap;
  assign epochWrap = goldenCnt == CNT_W'(GOLDEN_EPOCH - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      goldenCnt <= '0;
      goldenId <= '0;
    end else if (!stall) begin
      goldenCnt <= epochWrap ? '0 : goldenCnt + 1'b1;
      goldenId <= goldenId + ID_W'(epochWrap);
    end
`endif

  flit_prio_cmp #(.AGE_W(AGE_W), .ID_W(ID_W)) prioCmp (
    .valid0   (inFlit0[VALID_BIT]),
    .age0     (age0),
    .id0      (inFlit0[ID_MSB:ID_LSB]),
    .valid1   (inFlit1[VALID_BIT]),
    .age1     (age1),
    .id1      (inFlit1[ID_MSB:ID_LSB]),
`ifdef PERMUTER_GOLDEN_PRIORITY_EN
    .goldenId (goldenId),
`endif
    .lane1Wins(lane1Wins)
  );

  always_comb begin
    next0 = inFlit0;
    next1 = inFlit1;
    next0[AGE_MSB:AGE_LSB] = (inFlit0[VALID_BIT] && !(&age0)) ? age0 + 1'b1 : age0;
    next1[AGE_MSB:AGE_LSB] = (inFlit1[VALID_BIT] && !(&age1)) ? age1 + 1'b1 : age1;
    winner = lane1Wins ? LANE1 : LANE0;
    want = (winner == LANE1) ? inFlit1[WANT_BIT] : inFlit0[WANT_BIT];
    // swap means lane 0 heads to output 1; the loser takes whatever output remains
    swapNext = (inFlit0[VALID_BIT] | inFlit1[VALID_BIT]) & ((winner == LANE0) ? want : ~want);
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      outFlit0 <= '0;
      outFlit1 <= '0;
      swap <= 1'b0;
    end else if (!stall) begin
      outFlit0 <= next0;
      outFlit1 <= next1;
      swap <= swapNext;
    end
endmodule

// File: tb/tb_permuter_swap_stage.sv
// tb_permuter_swap_stage: directed and randomized checks of the swap stage against a ranking model.
module tb_permuter_swap_stage;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic stall = 1'b0;
  logic [63:0] inFlit0 = '0, inFlit1 = '0;
  logic [63:0] outFlit0, outFlit1;
  logic swap;
  int total = 0;
  int bad = 0;

  permuter_swap_stage dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .inFlit0(inFlit0), .inFlit1(inFlit1),
    .outFlit0(outFlit0), .outFlit1(outFlit1), .swap(swap)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input logic v, input logic [3:0] pv, input logic [7:0] age,
                                     input logic [7:0] id, input logic [42:0] pay);
    return {v, pv, age, id, pay};
  endfunction

  // Rank each flit by (valid, age, smaller id, lane 0 preference); the winner's PV bit picks its output.
  function automatic logic [128:0] model(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] o0, o1;
    logic [17:0] k0, k1;
    logic w, want, dest0;
    o0 = a;
    o1 = b;
    if (a[63]) o0[58:51] = (a[58:51] == 8'hFF) ? 8'hFF : a[58:51] + 8'd1;
    if (b[63]) o1[58:51] = (b[58:51] == 8'hFF) ? 8'hFF : b[58:51] + 8'd1;
    dest0 = 1'b0;
    if (a[63] || b[63]) begin
      k0 = {a[63], a[58:51], ~a[50:43], 1'b1};
      k1 = {b[63], b[58:51], ~b[50:43], 1'b0};
      w = k1 > k0;
      want = w ? b[59] : a[59];
      dest0 = w ? ~want : want;
    end
    return {o0, o1, dest0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd_flit();
    logic [7:0] ages [4] = '{8'd0, 8'd7, 8'd200, 8'hFF};
    logic [63:0] f;
    f = {$urandom, $urandom};
    f[58:51] = ($urandom_range(0, 1) == 1) ? ages[$urandom_range(0, 3)] : 8'($urandom);
    f[50:43] = 8'($urandom_range(0, 3));
    return f;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    inFlit0 = rnd_flit();
    inFlit1 = rnd_flit();
    repeat (3) step();
    total++;
    if ({outFlit0, outFlit1, swap} !== 129'd0) begin
      bad++;
      $display("FAIL reset: got %h %h %b want all zero", outFlit0, outFlit1, swap);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_idle();
    inFlit0 = '0;
    inFlit1 = '0;
    repeat (4) begin
      step();
      total++;
      if ({outFlit0, outFlit1, swap} !== 129'd0) begin
        bad++;
        $display("FAIL idle: got %h %h %b want all zero", outFlit0, outFlit1, swap);
      end
    end
  endtask

  task automatic test_directed();
    logic [63:0] a [5], b [5], ea [5], eb [5];
    logic es [5];
    a[0] = mk(1, 4'b0001, 8'd5, 8'd4, 43'h1234);   b[0] = mk(1, 4'b0000, 8'd3, 8'd7, 43'h55);
    ea[0] = mk(1, 4'b0001, 8'd6, 8'd4, 43'h1234);  eb[0] = mk(1, 4'b0000, 8'd4, 8'd7, 43'h55);  es[0] = 1;
    a[1] = mk(1, 4'b1110, 8'd7, 8'd9, 43'h1);      b[1] = mk(1, 4'b0110, 8'd7, 8'd2, 43'h2);
    ea[1] = mk(1, 4'b1110, 8'd8, 8'd9, 43'h1);     eb[1] = mk(1, 4'b0110, 8'd8, 8'd2, 43'h2);   es[1] = 1;
    a[2] = mk(0, 4'b1111, 8'd9, 8'd1, 43'h3);      b[2] = mk(1, 4'b0001, 8'hFF, 8'd3, 43'h4);
    ea[2] = a[2];                                  eb[2] = b[2];                                es[2] = 0;
    a[3] = mk(0, 4'b0001, 8'd9, 8'd1, 43'h3);      b[3] = mk(1, 4'b0000, 8'hFF, 8'd3, 43'h4);
    ea[3] = a[3];                                  eb[3] = b[3];                                es[3] = 1;
    a[4] = mk(1, 4'b0000, 8'd4, 8'd6, 43'h7);      b[4] = mk(1, 4'b0001, 8'd4, 8'd6, 43'h8);
    ea[4] = mk(1, 4'b0000, 8'd5, 8'd6, 43'h7);     eb[4] = mk(1, 4'b0001, 8'd5, 8'd6, 43'h8);   es[4] = 0;
    for (int i = 0; i < 5; i++) begin
      inFlit0 = a[i];
      inFlit1 = b[i];
      step();
      total++;
      if ({outFlit0, outFlit1, swap} !== {ea[i], eb[i], es[i]}) begin
        bad++;
        $display("FAIL directed[%0d]: got %h %h %b want %h %h %b", i, outFlit0, outFlit1, swap, ea[i], eb[i], es[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [128:0] exp;
    for (int i = 0; i < 300; i++) begin
      inFlit0 = rnd_flit();
      inFlit1 = rnd_flit();
      exp = model(inFlit0, inFlit1);
      step();
      total++;
      if ({outFlit0, outFlit1, swap} !== exp) begin
        bad++;
        $display("FAIL random[%0d]: in %h %h got %h %h %b want %h %h %b", i, inFlit0, inFlit1,
                 outFlit0, outFlit1, swap, exp[128:65], exp[64:1], exp[0]);
      end
    end
  endtask

  task automatic test_stall_reset();
    logic [128:0] exp;
    inFlit0 = mk(1, 4'b0001, 8'd5, 8'd4, 43'h9);
    inFlit1 = mk(1, 4'b0000, 8'd3, 8'd7, 43'hA);
    exp = model(inFlit0, inFlit1);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inFlit0 = rnd_flit();
      inFlit1 = rnd_flit();
      step();
      total++;
      if ({outFlit0, outFlit1, swap} !== exp) begin
        bad++;
        $display("FAIL stall[%0d]: got %h %h %b want %h %h %b", i, outFlit0, outFlit1, swap,
                 exp[128:65], exp[64:1], exp[0]);
      end
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++;
    if ({outFlit0, outFlit1, swap} !== 129'd0) begin
      bad++;
      $display("FAIL async_reset: got %h %h %b want all zero", outFlit0, outFlit1, swap);
    end
    step();
    @(negedge clk);
    stall = 1'b0;
    reset_n = 1'b1;
    inFlit0 = rnd_flit();
    inFlit1 = rnd_flit();
    exp = model(inFlit0, inFlit1);
    step();
    total++;
    if ({outFlit0, outFlit1, swap} !== exp) begin
      bad++;
      $display("FAIL after_reset: got %h %h %b want %h %h %b", outFlit0, outFlit1, swap,
               exp[128:65], exp[64:1], exp[0]);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_directed();
    test_random();
    test_stall_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
